// File: rtl/light_seq_monitor_pkg.sv
// Shared lamp-phase and monitor-state encodings, plus default phase timing
// used by both the traffic-light controller and its sequence monitor.
package light_seq_monitor_pkg;

  localparam logic [1:0] PH_RED    = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;
  localparam logic [1:0] PH_BAD    = 2'd3;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam int DEF_RED_TICKS    = 10;
  localparam int DEF_GREEN_TICKS  = 4;
  localparam int DEF_YELLOW_TICKS = 3;

  function automatic logic [1:0] decode_phase(input logic r, input logic g, input logic y);
    case ({r, g, y})
      3'b100:  return PH_RED;
      3'b010:  return PH_GREEN;
      3'b001:  return PH_YELLOW;
      default: return PH_BAD;
    endcase
  endfunction

endpackage

// File: rtl/light_phase_decode.sv
// Input stage of the sequence monitor: registers lamps and tick once, decodes the
// phase and flags the cycle in which the registered phase differs from the last one.
module light_phase_decode
  import light_seq_monitor_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       red_i,
  input  logic       green_i,
  input  logic       yellow_i,
  input  logic       tick_i,
  output logic       vld_o,
  output logic [1:0] phase_o,
  output logic [1:0] prev_phase_o,
  output logic       phase_chg_o,
  output logic       tick_o
);

  logic       red_q, green_q, yellow_q, tick_q, vld_q;
  logic [1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      red_q    <= 1'b0;
      green_q  <= 1'b0;
      yellow_q <= 1'b0;
      tick_q   <= 1'b0;
      vld_q    <= 1'b0;
      prev_q   <= PH_BAD;
    end else begin
      red_q    <= red_i;
      green_q  <= green_i;
      yellow_q <= yellow_i;
      tick_q   <= tick_i;
      vld_q    <= 1'b1;
      prev_q   <= phase_o;
    end
  end

  // vld_o stays low until the lamp registers hold a real sample, so the
  // all-zero reset contents are never mistaken for a dark-lamp fault.
  assign vld_o        = vld_q;
  assign phase_o      = decode_phase(red_q, green_q, yellow_q);
  assign prev_phase_o = prev_q;
  assign phase_chg_o  = vld_q && (phase_o != prev_q);
  assign tick_o       = tick_q;

endmodule

// File: rtl/light_seq_monitor.sv
// Traffic-light lamp sequence monitor: one-hot, order and dwell checks with sticky flags.
// Define LIGHT_SEQ_MONITOR_STUCK_EN to flag an over-long phase before it ends.
module light_seq_monitor
  import light_seq_monitor_pkg::*;
#(
  parameter int RED_TICKS    = DEF_RED_TICKS,
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int DWELL_TOL    = 0,
  parameter int CNT_W        = 8
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             green,
  input  logic             yellow,
  input  logic             tick,
  input  logic             clr,
  output logic [1:0]       phase,
  output logic             synced,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_dwell,
  output logic             fault,
  output logic [CNT_W-1:0] cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             vld, phase_chg, tick_r, seq_ok;
  logic [1:0]       prev_phase;
  state_e           state_q, state_d;
  logic             err_onehot_q, err_onehot_d, err_seq_q, err_seq_d, err_dwell_q, err_dwell_d;
  logic [CNT_W-1:0] dwell_q, dwell_d, dwell_nxt, cycles_q, cycles_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  function automatic int expected_ticks(input logic [1:0] ph);
    case (ph)
      PH_RED:    return RED_TICKS;
      PH_GREEN:  return GREEN_TICKS;
      PH_YELLOW: return YELLOW_TICKS;
      default:   return 0;
    endcase
  endfunction

  // A saturated counter no longer knows the true length, so it always fails.
  function automatic logic dwell_fail(input logic [CNT_W-1:0] cnt, input logic [1:0] ph);
    logic signed [31:0] diff;
    diff = $signed(32'(cnt)) - expected_ticks(ph);
    if (diff < 0) diff = -diff;
    return (&cnt) || (diff > DWELL_TOL);
  endfunction

`ifdef LIGHT_SEQ_MONITOR_STUCK_EN
  function automatic logic dwell_over(input logic [CNT_W-1:0] cnt, input logic [1:0] ph);
    return (&cnt) || ($signed(32'(cnt)) > (expected_ticks(ph) + DWELL_TOL));
  endfunction
`endif

  light_phase_decode u_decode (
    .clk_i        (clk),
    .rst_ni       (reset),
    .red_i        (red),
    .green_i      (green),
    .yellow_i     (yellow),
    .tick_i       (tick),
    .vld_o        (vld),
    .phase_o      (phase),
    .prev_phase_o (prev_phase),
    .phase_chg_o  (phase_chg),
    .tick_o       (tick_r)
  );

  assign seq_ok = ((prev_phase == PH_RED)    && (phase == PH_GREEN))  ||
                  ((prev_phase == PH_GREEN)  && (phase == PH_YELLOW)) ||
                  ((prev_phase == PH_YELLOW) && (phase == PH_RED));

  // A tick landing on the change cycle already belongs to the new phase.
  assign dwell_nxt = phase_chg ? (tick_r ? CNT_ONE : '0)
                               : (tick_r ? sat_inc(dwell_q) : dwell_q);

  always_comb begin
    state_d      = state_q;
    err_onehot_d = err_onehot_q;
    err_seq_d    = err_seq_q;
    err_dwell_d  = err_dwell_q;
    dwell_d      = dwell_q;
    cycles_d     = cycles_q;
    unique case (state_q)
      ST_SYNC: begin
        if (vld) begin
          dwell_d = dwell_nxt;
          if (phase == PH_BAD) begin
            err_onehot_d = 1'b1;
            state_d      = ST_FAULT;
          end else if (phase_chg && (prev_phase == PH_YELLOW) && (phase == PH_RED)) begin
            state_d = ST_TRACK;
          end
        end
      end
      ST_TRACK: begin
        dwell_d = dwell_nxt;
        // A change into the invalid phase is reported only as a one-hot error.
        if (phase == PH_BAD) begin
          err_onehot_d = 1'b1;
          state_d      = ST_FAULT;
        end else if (phase_chg) begin
          if (dwell_fail(dwell_q, prev_phase)) err_dwell_d = 1'b1;
          if (!seq_ok) err_seq_d = 1'b1;
          if (dwell_fail(dwell_q, prev_phase) || !seq_ok) begin
            state_d = ST_FAULT;
          end else if ((prev_phase == PH_YELLOW) && (phase == PH_RED)) begin
            cycles_d = sat_inc(cycles_q);
          end
        end
`ifdef LIGHT_SEQ_MONITOR_STUCK_EN
        else if (dwell_over(dwell_nxt, phase)) begin
          err_dwell_d = 1'b1;
          state_d     = ST_FAULT;
        end
`endif
      end
      default: ;
    endcase
    if (clr) begin
      err_onehot_d = 1'b0;
      err_seq_d    = 1'b0;
      err_dwell_d  = 1'b0;
      dwell_d      = '0;
      state_d      = ST_SYNC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_SYNC;
      err_onehot_q <= 1'b0;
      err_seq_q    <= 1'b0;
      err_dwell_q  <= 1'b0;
      dwell_q      <= '0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      err_onehot_q <= err_onehot_d;
      err_seq_q    <= err_seq_d;
      err_dwell_q  <= err_dwell_d;
      dwell_q      <= dwell_d;
      cycles_q     <= cycles_d;
    end
  end

  assign synced     = (state_q == ST_TRACK);
  assign err_onehot = err_onehot_q;
  assign err_seq    = err_seq_q;
  assign err_dwell  = err_dwell_q;
  assign fault      = err_onehot_q | err_seq_q | err_dwell_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_light_seq_monitor.sv
// Bench for light_seq_monitor: two instances (DWELL_TOL 0 and 1) share stimulus;
// expectations are queued at drive time and compared two clocks later.
module tb_light_seq_monitor;

`ifdef LIGHT_SEQ_MONITOR_STUCK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b0;
  logic red = 1'b0, green = 1'b0, yellow = 1'b0, tick = 1'b0, clr = 1'b0;
  logic [1:0] phase0, phase1;
  logic synced0, synced1, eo0, eo1, es0, es1, ed0, ed1, f0, f1;
  logic [7:0] cyc0, cyc1;
  logic lr = 1'b0, lg = 1'b0, ly = 1'b0;

  always #5 clk = ~clk;

  light_seq_monitor #(.DWELL_TOL(0)) dut0 (
    .clk(clk), .reset(reset), .red(red), .green(green), .yellow(yellow), .tick(tick), .clr(clr),
    .phase(phase0), .synced(synced0), .err_onehot(eo0), .err_seq(es0), .err_dwell(ed0),
    .fault(f0), .cycles(cyc0)
  );

  light_seq_monitor #(.DWELL_TOL(1)) dut1 (
    .clk(clk), .reset(reset), .red(red), .green(green), .yellow(yellow), .tick(tick), .clr(clr),
    .phase(phase1), .synced(synced1), .err_onehot(eo1), .err_seq(es1), .err_dwell(ed1),
    .fault(f1), .cycles(cyc1)
  );

  typedef struct {
    string      nm;
    bit         chk;
    bit         ph_only;
    logic [1:0] ph;
    bit         sy, eo, es, ed;
    int         cy;
    bit         f1;
  } exp_t;

  typedef struct {
    logic       r, g, y;
    logic [1:0] ph;
  } dec_t;

  exp_t sb[$];
  exp_t nochk;
  dec_t dec_tab[8];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(string nm, logic [1:0] ph, bit sy, bit eo, bit es, bit ed, int cy, bit ft);
    exp_t e;
    e.nm = nm; e.chk = 1'b1; e.ph_only = 1'b0; e.ph = ph;
    e.sy = sy; e.eo = eo; e.es = es; e.ed = ed; e.cy = cy; e.f1 = ft;
    return e;
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic score(input exp_t e);
    cmp({e.nm, ".phase"}, phase0, e.ph);
    if (!e.ph_only) begin
      cmp({e.nm, ".synced"}, synced0, e.sy);
      cmp({e.nm, ".err_onehot"}, eo0, e.eo);
      cmp({e.nm, ".err_seq"}, es0, e.es);
      cmp({e.nm, ".err_dwell"}, ed0, e.ed);
      cmp({e.nm, ".fault"}, f0, e.eo | e.es | e.ed);
      cmp({e.nm, ".cycles"}, cyc0, e.cy);
      cmp({e.nm, ".fault_tol1"}, f1, e.f1);
    end
  endtask

  task automatic cyc(input bit t, input bit c, input exp_t e);
    exp_t x;
    @(negedge clk);
    if (sb.size() == 2) begin
      x = sb.pop_front();
      if (x.chk) score(x);
    end
    red = lr; green = lg; yellow = ly; tick = t; clr = c;
    sb.push_back(e);
  endtask

  task automatic lamps(input logic r, input logic g, input logic y);
    lr = r; lg = g; ly = y;
  endtask

  // ph: 0 red, 1 green, 2 yellow; first tick coincides with the lamp change
  task automatic run(input int ph, input int n);
    lamps(ph == 0, ph == 1, ph == 2);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, nochk);
      cyc(1'b0, 1'b0, nochk);
    end
  endtask

  task automatic chk(input exp_t e);
    cyc(1'b0, 1'b0, e);
    cyc(1'b0, 1'b0, nochk);
  endtask

  task automatic flush;
    cyc(1'b0, 1'b0, nochk);
    cyc(1'b0, 1'b0, nochk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    red = lr; green = lg; yellow = ly; tick = 1'b0; clr = 1'b0;
    sb.delete();
    #1;
    cmp("rst.phase", phase0, 3);
    cmp("rst.synced", synced0, 0);
    cmp("rst.err_onehot", eo0, 0);
    cmp("rst.err_seq", es0, 0);
    cmp("rst.err_dwell", ed0, 0);
    cmp("rst.fault", f0, 0);
    cmp("rst.cycles", cyc0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    exp_t e;
    dec_tab[0] = '{1'b0, 1'b0, 1'b0, 2'd3};
    dec_tab[1] = '{1'b1, 1'b0, 1'b0, 2'd0};
    dec_tab[2] = '{1'b0, 1'b1, 1'b0, 2'd1};
    dec_tab[3] = '{1'b0, 1'b0, 1'b1, 2'd2};
    dec_tab[4] = '{1'b1, 1'b1, 1'b0, 2'd3};
    dec_tab[5] = '{1'b1, 1'b0, 1'b1, 2'd3};
    dec_tab[6] = '{1'b0, 1'b1, 1'b1, 2'd3};
    dec_tab[7] = '{1'b1, 1'b1, 1'b1, 2'd3};

    lamps(1'b1, 1'b0, 1'b0);
    do_reset();

    // nominal cycles: sync on first Yellow->Red, then count
    run(0, 10); run(1, 4); run(2, 3); run(0, 10);
    chk(mk("sync1", 0, 1, 0, 0, 0, 0, 0));
    run(1, 4); run(2, 3); run(0, 10);
    chk(mk("cyc1", 0, 1, 0, 0, 0, 1, 0));
    run(1, 4); run(2, 3); run(0, 10);
    chk(mk("cyc2", 0, 1, 0, 0, 0, 2, 0));

    // Green one tick long: TOL 0 flags, TOL 1 does not
    run(1, 5);
    chk(mk("g5_pre", 1, !STK, 0, 0, STK, 2, 0));
    run(2, 1);
    chk(mk("g5_dwell", 2, 0, 0, 0, 1, 2, 0));
    run(2, 2); run(0, 10);
    chk(mk("fault_hold", 0, 0, 0, 0, 1, 2, 0));

    // clear, resync, illegal Red->Yellow, clear again
    cyc(1'b0, 1'b1, nochk);
    chk(mk("clr1", 0, 0, 0, 0, 0, 2, 0));
    run(1, 4); run(2, 3); run(0, 10);
    chk(mk("resync", 0, 1, 0, 0, 0, 2, 0));
    run(2, 3);
    chk(mk("r2y", 2, 0, 0, 1, 0, 2, 1));
    cyc(1'b0, 1'b1, nochk);
    chk(mk("clr2", 2, 0, 0, 0, 0, 2, 0));
    run(0, 10);
    chk(mk("resync2", 0, 1, 0, 0, 0, 2, 0));

    // one-clock red+green overlap, then all lamps dark
    lamps(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, mk("glitch", 0, 0, 1, 0, 0, 2, 1));
    lamps(1'b1, 1'b0, 1'b0);
    chk(mk("glitch_hold", 0, 0, 1, 0, 0, 2, 1));
    cyc(1'b0, 1'b1, nochk);
    chk(mk("clr3", 0, 0, 0, 0, 0, 2, 0));
    lamps(1'b0, 1'b0, 1'b0);
    chk(mk("dark", 3, 0, 1, 0, 0, 2, 1));
    lamps(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, nochk);
    chk(mk("clr4", 2, 0, 0, 0, 0, 2, 0));

    // tick on the Red->Green change counts for Green; clr beats an illegal change
    run(0, 10);
    chk(mk("sync3", 0, 1, 0, 0, 0, 2, 0));
    run(1, 4); run(2, 3);
    chk(mk("tick_coinc", 2, 1, 0, 0, 0, 2, 0));
    lamps(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, nochk);
    cyc(1'b0, 1'b1, nochk);
    chk(mk("clr_vs_seq", 1, 0, 0, 0, 0, 2, 0));

    // Red held for an 11th tick
    run(2, 3); run(0, 10);
    chk(mk("sync4", 0, 1, 0, 0, 0, 2, 0));
    cyc(1'b1, 1'b0, nochk);
    chk(mk("stuck", 0, !STK, 0, 0, STK, 2, 0));
    run(1, 1);
    chk(mk("late_dwell", 1, 0, 0, 0, 1, 2, 0));
    flush();

    // reset mid-operation, then normal operation again
    lamps(1'b1, 1'b0, 1'b0);
    do_reset();
    run(0, 10);
    chk(mk("post_rst", 0, 0, 0, 0, 0, 0, 0));
    run(1, 4); run(2, 3); run(0, 10);
    chk(mk("post_rst_sync", 0, 1, 0, 0, 0, 0, 0));
    run(1, 4); run(2, 3); run(0, 3);
    chk(mk("post_rst_cyc", 0, 1, 0, 0, 0, 1, 0));

    // phase decode over all lamp combinations
    for (int i = 0; i < 8; i++) begin
      lamps(dec_tab[i].r, dec_tab[i].g, dec_tab[i].y);
      e = mk($sformatf("dec%0d", i), dec_tab[i].ph, 0, 0, 0, 0, 0, 0);
      e.ph_only = 1'b1;
      chk(e);
    end
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
